// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - four-way signal phase sequencer with optional pedestrian walk phase
// Optional feature macro: PED_CROSS_EN enables the WALK phase, request latch and walk lamp.
module traffic_phase_sequencer #(
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic [5:0] sec_left,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    NS_G = 3'd0, NS_Y = 3'd1, AR1 = 3'd2, EW_G = 3'd3,
    EW_Y = 3'd4, AR2  = 3'd5, WLK = 3'd6, BAD  = 3'd7
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // A zero duration would stall the countdown, so it is promoted to one tick.
  localparam logic [5:0] G_T  = (GREEN_S  == 0) ? 6'd1 : 6'(GREEN_S);
  localparam logic [5:0] Y_T  = (YELLOW_S == 0) ? 6'd1 : 6'(YELLOW_S);
  localparam logic [5:0] AR_T = (ALLRED_S == 0) ? 6'd1 : 6'(ALLRED_S);
  localparam logic [5:0] W_T  = (WALK_S   == 0) ? 6'd1 : 6'(WALK_S);

  state_t     state_q, state_d;
  logic [5:0] sec_d;
  logic [2:0] ns_d, ew_d;
  logic       walk_d, ped_d;

  assign phase = state_q;

`ifndef PED_CROSS_EN
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AR2;
      sec_left    <= AR_T;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_left    <= sec_d;
      ns_light    <= ns_d;
      ew_light    <= ew_d;
      walk        <= walk_d;
      ped_pending <= ped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_left;
    ns_d    = RED;
    ew_d    = RED;
    walk_d  = 1'b0;
    ped_d   = 1'b0;

    if (tick) begin
      if (state_q == BAD) begin
        state_d = AR2;
        sec_d   = AR_T;
      end else if (sec_left > 6'd1) begin
        sec_d = sec_left - 6'd1;
      end else begin
        case (state_q)
          NS_G:    state_d = NS_Y;
          NS_Y:    state_d = AR1;
          AR1:     state_d = EW_G;
          EW_G:    state_d = EW_Y;
          EW_Y:    state_d = AR2;
`ifdef PED_CROSS_EN
          // A request arriving on the exit tick itself is still honoured.
          AR2:     state_d = (ped_pending || ped_req) ? WLK : NS_G;
`else
          AR2:     state_d = NS_G;
`endif
          WLK:     state_d = NS_G;
          default: state_d = AR2;
        endcase
        case (state_d)
          NS_G, EW_G: sec_d = G_T;
          NS_Y, EW_Y: sec_d = Y_T;
          WLK:        sec_d = W_T;
          default:    sec_d = AR_T;
        endcase
      end
    end

    case (state_d)
      NS_G:    ns_d = GRN;
      NS_Y:    ns_d = YEL;
      EW_G:    ew_d = GRN;
      EW_Y:    ew_d = YEL;
      default: ;
    endcase

`ifdef PED_CROSS_EN
    walk_d = (state_d == WLK);
    if (state_d == WLK && state_q != WLK) begin
      ped_d = 1'b0;
    end else if (ped_req && state_q != WLK) begin
      ped_d = 1'b1;
    end else begin
      ped_d = ped_pending;
    end
`endif
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - scoreboard bench for traffic_phase_sequencer against a phase-table model
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_pending;
  logic [5:0] sec_left;

  traffic_phase_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .phase(phase), .sec_left(sec_left), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] sec;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       pend;
  } exp_t;

  // Phase tables indexed by phase code: duration, successor, lamps.
  int         dur_t [8] = '{10, 3, 1, 10, 3, 1, 8, 1};
  int         next_t[8] = '{1, 2, 3, 4, 5, 0, 0, 5};
  logic [2:0] ns_t  [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_t  [8] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};

`ifdef PED_CROSS_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_phase = 5;
  int   m_sec = 1;
  bit   m_pend = 1'b0;
  int   cyc = 0;

  task automatic step(input logic r, input logic t, input logic p);
    exp_t e;
    int   old_phase;
    @(negedge clk);
    rst = r; tick = t; ped_req = p;
    old_phase = m_phase;
    if (r) begin
      m_phase = 5; m_sec = dur_t[5]; m_pend = 1'b0;
    end else begin
      if (t) begin
        if (m_sec > 1) m_sec = m_sec - 1;
        else begin
          m_phase = next_t[m_phase];
          if (old_phase == 5 && PED && (m_pend || p)) m_phase = 6;
          m_sec = dur_t[m_phase];
        end
      end
      if (PED) begin
        if (m_phase == 6 && old_phase != 6) m_pend = 1'b0;
        else if (p && old_phase != 6) m_pend = 1'b1;
      end
    end
    e.ph = 3'(m_phase); e.sec = 6'(m_sec);
    e.ns = ns_t[m_phase]; e.ew = ew_t[m_phase];
    e.wk = (m_phase == 6); e.pend = m_pend;
    q.push_back(e);
  endtask

  // Monitor: compares every registered output set, plus lamp safety and loop length.
  int   tick_cnt = 0;
  bit   loop_valid = 1'b0;
  logic [2:0] prev_phase = 3'd5;
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {phase, sec_left, ns_light, ew_light, walk, ped_pending};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL scoreboard cyc=%0d got ph=%0d sec=%0d ns=%b ew=%b walk=%b pend=%b, want ph=%0d sec=%0d ns=%b ew=%b walk=%b pend=%b",
                   cyc, got.ph, got.sec, got.ns, got.ew, got.wk, got.pend,
                   e.ph, e.sec, e.ns, e.ew, e.wk, e.pend);
        end
        n_checks++;
        if (walk && (ns_light[1:0] != 2'b00 || ew_light[1:0] != 2'b00)) begin
          n_fail++;
          $display("FAIL walk_safety cyc=%0d walk=%b ns=%b ew=%b, want no green/yellow", cyc, walk, ns_light, ew_light);
        end
        if (rst) begin
          loop_valid = 1'b0;
          tick_cnt = 0;
        end else begin
          if (tick) tick_cnt++;
          if (phase == 3'd0 && prev_phase != 3'd0) begin
            if (loop_valid) begin
              n_checks++;
              if (tick_cnt != ((prev_phase == 3'd6) ? 36 : 28)) begin
                n_fail++;
                $display("FAIL loop_ticks cyc=%0d got %0d, want %0d", cyc, tick_cnt,
                         (prev_phase == 3'd6) ? 36 : 28);
              end
            end
            loop_valid = 1'b1;
            tick_cnt = 0;
          end
        end
        prev_phase = phase;
      end
    end
  end

  initial begin
    step(1, 0, 0);
    step(1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    // Request coinciding with the final AR2 tick, then presses during the walk phase.
    step(0, 1, 1);
    for (int i = 0; i < 40; i++) step(0, (i % 2) == 1, (i % 3) == 0);
    // Full unrequested cycles with tick every cycle.
    step(1, 0, 0);
    for (int i = 0; i < 70; i++) step(0, 1, 0);
    // Reset mid-green at four seconds left.
    step(1, 0, 0);
    for (int i = 0; i < 200 && !(m_phase == 0 && m_sec == 4); i++) step(0, 1, 0);
    step(1, 1, 0);
    // Request pulse during east-west green, then held request.
    for (int i = 0; i < 200 && m_phase != 3; i++) step(0, 1, 0);
    step(0, 0, 1);
    for (int i = 0; i < 60; i++) step(0, 1, 0);
    for (int i = 0; i < 150; i++) step(0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    step(0, 0, 0);
    step(0, 0, 0);
    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
